// File: rtl/lcd_sched_pkg.sv
// Shared state encodings, follow-on action codes and LCD command words for
// the LCD write scheduler.
package lcd_sched_pkg;

    localparam logic [2:0] S_INIT_ISSUE = 3'd0;
    localparam logic [2:0] S_INIT_WAIT  = 3'd1;
    localparam logic [2:0] S_IDLE       = 3'd2;
    localparam logic [2:0] S_ISSUE      = 3'd3;
    localparam logic [2:0] S_WAIT       = 3'd4;

    typedef enum logic [1:0] {
        NA_NONE = 2'd0,
        NA_WRAP = 2'd1,
        NA_HOME = 2'd2
    } next_action_t;

    // What the instruction currently in flight is, so its completion can
    // update the cursor bookkeeping.
    typedef enum logic [1:0] {
        K_CHAR  = 2'd0,
        K_WRAP  = 2'd1,
        K_CLEAR = 2'd2,
        K_HOME  = 2'd3
    } cmd_kind_t;

    localparam logic [8:0] LCD_FUNCTION_SET = 9'h038;
    localparam logic [8:0] LCD_DISPLAY_ON   = 9'h00C;
    localparam logic [8:0] LCD_CLEAR        = 9'h001;
    localparam logic [8:0] LCD_ENTRY_MODE   = 9'h006;
    localparam logic [8:0] LCD_LINE1_HOME   = 9'h080;
    localparam logic [8:0] LCD_LINE2_HOME   = 9'h0C0;

    localparam logic [2:0] INIT_LAST = 3'd4;

    function automatic logic [8:0] init_cmd(input logic [2:0] idx);
        logic [8:0] cmd;
        case (idx)
            3'd0:    cmd = LCD_FUNCTION_SET;
            3'd1:    cmd = LCD_DISPLAY_ON;
            3'd2:    cmd = LCD_CLEAR;
            3'd3:    cmd = LCD_ENTRY_MODE;
            default: cmd = LCD_LINE1_HOME;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Small synchronous character queue with push, pop and flush; pointers wrap
// modulo DEPTH (a power of two).
module lcd_char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Status flags, qualified push/pop and head-of-queue data.
    always_comb begin
        full      = (count == CW'(DEPTH));
        empty     = (count == CW'(0));
        push_ok_s = push & ~full & ~flush;
        pop_ok_s  = pop & ~empty & ~flush;
        rd_data   = mem_r[rd_ptr_r];
    end

    // Pointer and occupancy tracking; flush empties the queue at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count    <= CW'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count    <= CW'(0);
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            else           wr_ptr_r <= wr_ptr_r;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            else           rd_ptr_r <= rd_ptr_r;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= wr_data;
    end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Single owner of the LCD_controller handshake: power-up init, queued
// character writes, automatic line wrap and prioritised screen clear.
module lcd_write_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int LINE_CHARS     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                            Clock_50,
    input  logic                            Reset,
    input  logic [7:0]                      char_data,
    input  logic                            char_valid,
    output logic                            char_ready,
    input  logic                            clear_req,
    output logic                            LCD_start,
    output logic [8:0]                      LCD_instruction,
    input  logic                            LCD_done,
    output logic                            init_done,
    output logic                            busy,
    output logic [$clog2(LINE_CHARS)-1:0]   lcd_position,
    output logic                            lcd_line,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            timeout_err
);

    localparam int PW = $clog2(LINE_CHARS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] LAST_POS = PW'(LINE_CHARS - 1);

    logic [2:0]    state_r;
    next_action_t  next_action_r;
    cmd_kind_t     kind_r;
    logic [2:0]    init_idx_r;
    logic [TW-1:0] wait_cnt_r;
    logic          clear_pend_r;

    logic          clear_any_s;
    logic          push_s;
    logic          pop_s;
    logic          timeout_hit_s;
    logic          wait_done_s;
    logic [8:0]    wrap_cmd_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [7:0]    fifo_rd_data_s;

    lcd_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (Clock_50),
        .rst     (Reset),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (clear_req),
        .wr_data (char_data),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count)
    );

    // Handshake qualifiers; LCD_done is not trusted while the strobe is high.
    always_comb begin
        clear_any_s   = clear_pend_r | clear_req;
        char_ready    = ~fifo_full_s & ~clear_req;
        push_s        = char_valid & char_ready;
        pop_s         = (state_r == S_IDLE) & ~clear_any_s & ~fifo_empty_s;
        timeout_hit_s = (wait_cnt_r == TW'(TIMEOUT_CYCLES - 1));
        wait_done_s   = ~LCD_start & (LCD_done | timeout_hit_s);
        busy          = (state_r != S_IDLE) | ~fifo_empty_s | clear_pend_r;
        wrap_cmd_s    = {2'b01, ~lcd_line, 6'h00};
    end

    // Main sequencer: init, idle arbitration, issue/wait and chained commands.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state_r         <= S_INIT_ISSUE;
            next_action_r   <= NA_NONE;
            kind_r          <= K_CHAR;
            init_idx_r      <= 3'd0;
            wait_cnt_r      <= TW'(0);
            clear_pend_r    <= 1'b0;
            LCD_start       <= 1'b0;
            LCD_instruction <= 9'h000;
            init_done       <= 1'b0;
            lcd_position    <= PW'(0);
            lcd_line        <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            LCD_start <= 1'b0;
            if (clear_req) clear_pend_r <= 1'b1;
            case (state_r)
                S_INIT_ISSUE: begin
                    LCD_instruction <= init_cmd(init_idx_r);
                    LCD_start       <= 1'b1;
                    wait_cnt_r      <= TW'(0);
                    state_r         <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    if (wait_done_s) begin
                        if (timeout_hit_s) timeout_err <= 1'b1;
                        if (init_idx_r == INIT_LAST) begin
                            init_done <= 1'b1;
                            state_r   <= S_IDLE;
                        end else begin
                            init_idx_r <= init_idx_r + 3'd1;
                            state_r    <= S_INIT_ISSUE;
                        end
                    end else if (!LCD_start) begin
                        wait_cnt_r <= wait_cnt_r + TW'(1);
                    end
                end
                S_IDLE: begin
                    if (clear_any_s) begin
                        // Issuing now absorbs any request seen this same cycle.
                        clear_pend_r    <= 1'b0;
                        LCD_instruction <= LCD_CLEAR;
                        LCD_start       <= 1'b1;
                        kind_r          <= K_CLEAR;
                        next_action_r   <= NA_HOME;
                        state_r         <= S_ISSUE;
                    end else if (!fifo_empty_s) begin
                        LCD_instruction <= {1'b1, fifo_rd_data_s};
                        LCD_start       <= 1'b1;
                        kind_r          <= K_CHAR;
                        next_action_r   <= (lcd_position == LAST_POS) ? NA_WRAP : NA_NONE;
                        state_r         <= S_ISSUE;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt_r <= TW'(0);
                    state_r    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_done_s) begin
                        if (timeout_hit_s) timeout_err <= 1'b1;
                        case (kind_r)
                            K_CHAR:  lcd_position <= (next_action_r == NA_WRAP) ? PW'(0)
                                                                                : lcd_position + PW'(1);
                            K_WRAP:  lcd_line <= ~lcd_line;
                            K_HOME: begin
                                lcd_position <= PW'(0);
                                lcd_line     <= 1'b0;
                            end
                            default: lcd_line <= lcd_line;
                        endcase
                        case (next_action_r)
                            NA_WRAP: begin
                                LCD_instruction <= wrap_cmd_s;
                                LCD_start       <= 1'b1;
                                kind_r          <= K_WRAP;
                                state_r         <= S_ISSUE;
                            end
                            NA_HOME: begin
                                LCD_instruction <= LCD_LINE1_HOME;
                                LCD_start       <= 1'b1;
                                kind_r          <= K_HOME;
                                state_r         <= S_ISSUE;
                            end
                            default: state_r <= S_IDLE;
                        endcase
                        next_action_r <= NA_NONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TW'(1);
                    end
                end
                default: state_r <= S_INIT_ISSUE;
            endcase
        end
    end

endmodule
